// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: next-PC selection, circular return-address
// stack and interrupt entry/exit bookkeeping.
module pc_gen #(
  parameter int unsigned     PC_W       = 24,
  parameter logic [PC_W-1:0] START_PC   = PC_W'(389),
  parameter logic [PC_W-1:0] INCR       = PC_W'(1),
  parameter int unsigned     RAS_DEPTH  = 4,
  parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(0)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            call_valid,
  input  logic [PC_W-1:0] call_target,
  input  logic            ret_valid,
  input  logic            irq,
  input  logic            iret_valid,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_add,
  output logic [PC_W-1:0] epc,
  output logic            in_isr,
  output logic            irq_ack,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  epc_q, epc_d;
  logic             in_isr_q, in_isr_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [PTR_W-1:0] top_m1;
  logic             push;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];

  // top_q is the next write slot; the newest entry sits one below it
  assign top_m1    = top_q - PTR_W'(1);
  assign pc_add    = pc_q + INCR;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

  assign pc_out  = pc_q;
  assign epc     = epc_q;
  assign in_isr  = in_isr_q;
  assign irq_ack = ack_q;
  assign ras_err = err_q;

  // Next-PC priority: redirect > stall > irq > iret > ret > call > sequential
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    in_isr_d = in_isr_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    top_d    = top_q;
    push     = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (!stall) begin
      if (irq && !in_isr_q) begin
        epc_d    = pc_q;
        pc_d     = IRQ_VECTOR;
        in_isr_d = 1'b1;
        ack_d    = 1'b1;
      end else if (iret_valid) begin
        pc_d     = epc_q;
        in_isr_d = 1'b0;
        if (!in_isr_q) err_d = 1'b1;
      end else if (ret_valid) begin
        if (call_valid) err_d = 1'b1;
        if (ras_empty) begin
          pc_d  = pc_add;
          err_d = 1'b1;
        end else begin
          pc_d  = ras_q[top_m1];
          top_d = top_m1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (call_valid) begin
        push  = 1'b1;
        pc_d  = call_target;
        top_d = top_q + PTR_W'(1);
        // A full stack overwrites its oldest entry, which is the slot at top_q
        if (ras_full) err_d = 1'b1;
        else          cnt_d = cnt_q + CNT_W'(1);
      end else begin
        pc_d = pc_add;
      end
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= START_PC;
      epc_q    <= '0;
      in_isr_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      top_q    <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_isr_q <= in_isr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      top_q    <= top_d;
      if (push) ras_q[top_q] <= pc_add;
    end
  end

endmodule
